// File: rtl/alu_issue_pkg.sv
// Shared constants for the RV32I ALU issue slice: ALU op codes, opcodes, branch funct3 codes.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

  // ALU op implied by funct3 alone (no funct7 alternate forms)
  function automatic logic [3:0] f3_base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational RV32I decode: instruction word to ALU op, operand selects, immediate and writeback info.
module rv32_alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op,
  output a_sel_e      a_sel,
  output logic        b_imm,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        is_branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  always_comb begin
    op        = ALU_ADD;
    a_sel     = A_RS1;
    b_imm     = 1'b0;
    imm       = '0;
    wb_en     = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        wb_en = 1'b1;
        if (funct7 == 7'b0000000)                         op = f3_base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) op = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) op = ALU_SRA;
        else                                               illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        wb_en = 1'b1;
        b_imm = 1'b1;
        imm   = {{20{instr[31]}}, instr[31:20]};
        // Shift-immediate forms reuse imm[11:5] as a funct7 qualifier
        if (funct3 == 3'b001 && funct7 != 7'b0000000)      illegal = 1'b1;
        else if (funct3 == 3'b101 && funct7 == 7'b0100000) op = ALU_SRA;
        else if (funct3 == 3'b101 && funct7 != 7'b0000000) illegal = 1'b1;
        else                                               op = f3_base_op(funct3);
      end
      OPC_LUI: begin
        wb_en = 1'b1;
        a_sel = A_ZERO;
        b_imm = 1'b1;
        imm   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        wb_en = 1'b1;
        a_sel = A_PC;
        b_imm = 1'b1;
        imm   = {instr[31:12], 12'b0};
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (funct3)
          F3_BEQ, F3_BNE:   op = ALU_EQ;
          F3_BLT, F3_BGE:   op = ALU_SLT;
          F3_BLTU, F3_BGEU: op = ALU_SLTU;
          default:          illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op        = ALU_ADD;
      wb_en     = 1'b0;
      is_branch = 1'b0;
    end
    if (rd == 5'd0) wb_en = 1'b0;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage ALU issue/writeback pipeline around an external combinational ALU.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN adds the wb_illegal output.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_branch_en,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic            wb_illegal
`endif
);

  logic [3:0]      dec_op;
  a_sel_e          dec_a_sel;
  logic            dec_b_imm;
  logic [31:0]     dec_imm;
  logic [4:0]      dec_rd;
  logic            dec_wb_en;
  logic            dec_is_branch;
  logic            dec_illegal;

  rv32_alu_decode u_decode (
    .instr     (in_instr),
    .op        (dec_op),
    .a_sel     (dec_a_sel),
    .b_imm     (dec_b_imm),
    .imm       (dec_imm),
    .rd        (dec_rd),
    .wb_en     (dec_wb_en),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  logic            s1_valid_reg, s1_valid_next;
  logic            wb_valid_reg, wb_valid_next;
  logic [3:0]      alu_op_reg;
  logic [XLEN-1:0] alu_a_reg, alu_b_reg, a_next;
  logic [4:0]      s1_rd_reg;
  logic            s1_wb_en_reg, s1_is_branch_reg;
  logic [1:0]      s1_br_sel_reg;  // {compare-type, invert} from funct3[2], funct3[0]
  logic [XLEN-1:0] s1_br_target_reg;
  logic            wb_en_reg, br_taken_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg, br_target_reg;
  logic            s2_free, s1_adv, accept, br_cond;

  assign s2_free  = !wb_valid_reg || wb_ready;
  assign s1_adv   = s1_valid_reg && s2_free;
  assign in_ready = !s1_valid_reg || s2_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_next = s1_valid_reg;
    if (accept)      s1_valid_next = 1'b1;
    else if (s1_adv) s1_valid_next = 1'b0;
    wb_valid_next = wb_valid_reg;
    if (s1_adv)        wb_valid_next = 1'b1;
    else if (wb_ready) wb_valid_next = 1'b0;
  end

  always_comb begin
    case (dec_a_sel)
      A_PC:    a_next = in_pc;
      A_ZERO:  a_next = '0;
      default: a_next = in_rs1_data;
    endcase
  end

  assign br_cond = (s1_br_sel_reg[1] ? alu_result[0] : alu_branch_en) ^ s1_br_sel_reg[0];

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic s1_illegal_reg, wb_illegal_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_illegal_reg <= 1'b0;
      wb_illegal_reg <= 1'b0;
    end else begin
      if (accept) s1_illegal_reg <= dec_illegal;
      if (s1_adv) wb_illegal_reg <= s1_illegal_reg;
    end
  end
  assign wb_illegal = wb_illegal_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg     <= 1'b0;
      wb_valid_reg     <= 1'b0;
      alu_op_reg       <= ALU_ADD;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      s1_rd_reg        <= '0;
      s1_wb_en_reg     <= 1'b0;
      s1_is_branch_reg <= 1'b0;
      s1_br_sel_reg    <= '0;
      s1_br_target_reg <= '0;
      wb_en_reg        <= 1'b0;
      wb_rd_reg        <= '0;
      wb_data_reg      <= '0;
      br_taken_reg     <= 1'b0;
      br_target_reg    <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      wb_valid_reg <= wb_valid_next;
      if (accept) begin
        alu_op_reg       <= dec_op;
        alu_a_reg        <= a_next;
        alu_b_reg        <= dec_b_imm ? dec_imm : in_rs2_data;
        s1_rd_reg        <= dec_rd;
        s1_wb_en_reg     <= dec_wb_en && !dec_illegal;
        s1_is_branch_reg <= dec_is_branch;
        s1_br_sel_reg    <= {in_instr[14], in_instr[12]};
        s1_br_target_reg <= in_pc + dec_imm;
      end
      if (s1_adv) begin
        wb_en_reg     <= s1_wb_en_reg;
        wb_rd_reg     <= s1_rd_reg;
        wb_data_reg   <= alu_result;
        br_taken_reg  <= s1_is_branch_reg && br_cond;
        br_target_reg <= s1_br_target_reg;
      end
    end
  end

  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign wb_valid  = wb_valid_reg;
  assign wb_en     = wb_en_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_data   = wb_data_reg;
  assign br_taken  = br_taken_reg;
  assign br_target = br_target_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_branch_en;
  logic        wb_valid, wb_ready, wb_en, br_taken;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, br_target;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        wb_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_branch_en (alu_branch_en),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .br_taken      (br_taken),
    .br_target     (br_target)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .wb_illegal    (wb_illegal)
`endif
  );

  // Reference combinational ALU driven by the DUT's issue registers
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = alu_a << alu_b[4:0];
      4'd6: alu_result = alu_a >> alu_b[4:0];
      4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
    alu_branch_en = (alu_a == alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one accepting edge
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; wb_ready = 1'b1;
    in_instr = 32'hFFF00293; in_pc = 32'h0; in_rs1_data = 32'h5; in_rs2_data = 32'h6;
    #1;
    tick(); tick();
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_op",   {28'b0, alu_op}, 32'd0);
    chk("rst_alu_a",    alu_a, 32'd0);
    chk("rst_alu_b",    alu_b, 32'd0);
    chk("rst_wb_en",    {31'b0, wb_en}, 32'd0);
    chk("rst_wb_rd",    {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data",  wb_data, 32'd0);
    chk("rst_br_taken", {31'b0, br_taken}, 32'd0);
    chk("rst_br_target", br_target, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // ADDI x5,x0,-1
    issue(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    chk("addi_op", {28'b0, alu_op}, 32'd0);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_wbv_early", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("addi_wbv", {31'b0, wb_valid}, 32'd1);
    chk("addi_rd", {27'b0, wb_rd}, 32'd5);
    chk("addi_en", {31'b0, wb_en}, 32'd1);
    chk("addi_data", wb_data, 32'hFFFFFFFF);
    tick();
    chk("addi_drain", {31'b0, wb_valid}, 32'd0);

    // SRAI x1,x2,4 with rs1=0x80000000
    issue(32'h40415093, 32'h0, 32'h80000000, 32'h0);
    chk("srai_op", {28'b0, alu_op}, 32'd7);
    chk("srai_shamt", {27'b0, alu_b[4:0]}, 32'd4);
    tick();
    chk("srai_data", wb_data, 32'hF8000000);
    chk("srai_rd", {27'b0, wb_rd}, 32'd1);

    // SUB x7,x1,x2 : 10 - 3
    issue(32'h402083B3, 32'h0, 32'd10, 32'd3);
    chk("sub_op", {28'b0, alu_op}, 32'd1);
    tick();
    chk("sub_data", wb_data, 32'd7);

    // LUI x3,0x12345 and AUIPC x4,1 at pc 0x1000
    issue(32'h123451B7, 32'h0, 32'hDEADBEEF, 32'h0);
    chk("lui_a", alu_a, 32'd0);
    chk("lui_b", alu_b, 32'h12345000);
    issue(32'h00001217, 32'h1000, 32'hDEADBEEF, 32'h0);
    chk("lui_data", wb_data, 32'h12345000);
    chk("lui_rd", {27'b0, wb_rd}, 32'd3);
    chk("auipc_a", alu_a, 32'h1000);
    tick();
    chk("auipc_data", wb_data, 32'h2000);
    chk("auipc_rd", {27'b0, wb_rd}, 32'd4);

    // BNE x1,x2,+16 at pc 0x100, equal operands
    issue(32'h00209863, 32'h100, 32'd7, 32'd7);
    chk("bne_op", {28'b0, alu_op}, 32'd10);
    tick();
    chk("bne_target", br_target, 32'h110);
    chk("bne_taken", {31'b0, br_taken}, 32'd0);
    chk("bne_wb_en", {31'b0, wb_en}, 32'd0);
    chk("bne_wbv", {31'b0, wb_valid}, 32'd1);

    // BGEU x1,x2,+8 at pc 0x200: 1 >= 0xFFFFFFFF is false
    issue(32'h0020F463, 32'h200, 32'd1, 32'hFFFFFFFF);
    chk("bgeu_op", {28'b0, alu_op}, 32'd9);
    tick();
    chk("bgeu_nt_taken", {31'b0, br_taken}, 32'd0);
    chk("bgeu_target", br_target, 32'h208);
    // Operands swapped: 0xFFFFFFFF >= 1 unsigned is true
    issue(32'h0020F463, 32'h200, 32'hFFFFFFFF, 32'd1);
    tick();
    chk("bgeu_t_taken", {31'b0, br_taken}, 32'd1);

    // BEQ x1,x2,-8 at pc 0x4: target wraps
    issue(32'hFE208CE3, 32'h4, 32'd5, 32'd5);
    tick();
    chk("beq_taken", {31'b0, br_taken}, 32'd1);
    chk("beq_target", br_target, 32'hFFFFFFFC);

    // Illegal R-type funct7 and ADD to x0
    issue(32'h02000333, 32'h0, 32'd1, 32'd2);
    chk("ill_op", {28'b0, alu_op}, 32'd0);
    tick();
    chk("ill_wb_en", {31'b0, wb_en}, 32'd0);
    chk("ill_taken", {31'b0, br_taken}, 32'd0);
    issue(32'h00208033, 32'h0, 32'd1, 32'd2);
    tick();
    chk("rd0_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rd0_data", wb_data, 32'd3);
    tick();

    // Backpressure: ADDI x10,1 / x11,2 / x12,3 with wb_ready low
    wb_ready = 1'b0;
    in_rs1_data = 32'h0;
    in_valid = 1'b1; in_instr = 32'h00100513;
    chk("bp_ready0", {31'b0, in_ready}, 32'd1);
    tick();
    in_instr = 32'h00200593;
    tick();
    chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
    chk("bp_rd_a", {27'b0, wb_rd}, 32'd10);
    in_instr = 32'h00300613;
    tick();
    chk("bp_hold_rd", {27'b0, wb_rd}, 32'd10);
    chk("bp_hold_data", wb_data, 32'd1);
    tick();
    chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, wb_valid}, 32'd1);
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_rd_b", {27'b0, wb_rd}, 32'd11);
    chk("bp_data_b", wb_data, 32'd2);
    tick();
    chk("bp_rd_c", {27'b0, wb_rd}, 32'd12);
    chk("bp_data_c", wb_data, 32'd3);
    tick();
    chk("bp_drain", {31'b0, wb_valid}, 32'd0);

    // Reset with both stages occupied emits nothing
    wb_ready = 1'b0;
    issue(32'h00100513, 32'h0, 32'h0, 32'h0);
    issue(32'h00200593, 32'h0, 32'h0, 32'h0);
    chk("mid_full", {31'b0, wb_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    chk("mid_rst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("mid_rst_no_emit", {31'b0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
